// File: rtl/add_responder.sv
// rtl/add_responder.sv - operand/sum responder: (W+1)-bit adder feeding a DEPTH-entry result FIFO
module add_responder #(
    parameter int W     = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W:0]    out_sum,
    output logic [W-1:0]  out_a,
    output logic [W-1:0]  out_b,
    output logic [CW-1:0] txn_cnt,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0] mem_a   [DEPTH];
    logic [W-1:0] mem_b   [DEPTH];
    logic [W:0]   mem_sum [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [W:0]    sum;

    // Sum is widened before the add so the carry is never lost.
    assign sum       = {1'b0, in_a} + {1'b0, in_b};

    assign in_ready  = (count != FULL_CNT);
    assign full      = (count == FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_a     = mem_a[rd_ptr];
    assign out_b     = mem_b[rd_ptr];
    assign out_sum   = mem_sum[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_sum[wr_ptr] <= sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            txn_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + AW'(1);
                txn_cnt <= txn_cnt + CW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_add_responder.sv
// tb/tb_add_responder.sv - self-checking bench for add_responder against a queue-based model
module tb_add_responder;

    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W:0]    out_sum;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_b;
    logic [CW-1:0] txn_cnt;
    logic          full;

    add_responder #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_a(out_a), .out_b(out_b),
        .txn_cnt(txn_cnt), .full(full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of accepted operand pairs and a wrapping pop counter.
    typedef struct { int a; int b; } pair_t;
    pair_t m_q[$];
    int    m_cnt = 0;
    int    pop_log[$];

    always @(posedge clk) begin
        bit do_push, do_pop;
        if (!rst_n) begin
            m_q.delete();
            m_cnt = 0;
        end else begin
            do_push = in_valid && (m_q.size() < DEPTH);
            do_pop  = out_ready && (m_q.size() > 0);
            if (do_pop) begin
                void'(m_q.pop_front());
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
            if (do_push) m_q.push_back('{int'(in_a), int'(in_b)});
        end
    end

    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic          p_rst_n = 1'b0;
    logic [W:0]    p_sum;
    logic [W-1:0]  p_a, p_b;

    always @(negedge clk) begin
        chk("out_valid", out_valid, m_q.size() != 0);
        chk("in_ready", in_ready, m_q.size() != DEPTH);
        chk("full", full, m_q.size() == DEPTH);
        chk("txn_cnt", txn_cnt, m_cnt);
        if (m_q.size() != 0 && out_valid) begin
            chk("out_a", out_a, m_q[0].a);
            chk("out_b", out_b, m_q[0].b);
            chk("out_sum", out_sum, m_q[0].a + m_q[0].b);
        end
        if (p_valid && p_rst_n && !p_ready)
            chk("valid_held_without_pop", out_valid, 1);
        if (p_valid && p_rst_n && !p_ready && out_valid) begin
            chk("stable_sum", out_sum, p_sum);
            chk("stable_a", out_a, p_a);
            chk("stable_b", out_b, p_b);
        end
        if (out_valid && out_ready && rst_n) pop_log.push_back(int'(out_sum));
        p_valid = out_valid; p_ready = out_ready; p_rst_n = rst_n;
        p_sum = out_sum; p_a = out_a; p_b = out_b;
    end

    task automatic send(input int a, input int b);
        bit acc = 0;
        int n = 0;
        in_valid = 1'b1;
        in_a = W'(a);
        in_b = W'(b);
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (out_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_log(input string name, input int exp[]);
        chk({name, "_len"}, pop_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < pop_log.size(); i++)
            chk(name, pop_log[i], exp[i]);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_full", full, 0);
        chk("rst_txn_cnt", txn_cnt, 0);
        @(posedge clk);
        #1;

        // Single transactions with the consumer always ready.
        pop_log.delete();
        out_ready = 1'b1;
        send(1, 2); send(0, 9); send(4, 8); send(7, 9);
        drain();
        chk_log("single_sum", '{3, 9, 12, 16});
        chk("single_txn_cnt", txn_cnt, 4);

        // Largest operands exercise the carry bit.
        pop_log.delete();
        send(15, 15); send(15, 0);
        drain();
        chk_log("max_sum", '{30, 15});

        // Back-pressure: four fit, the fifth waits for space.
        do_reset();
        pop_log.delete();
        out_ready = 1'b0;
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        in_valid = 1'b1; in_a = 4'd0; in_b = 4'd5;
        repeat (2) @(negedge clk);
        chk("bp_full", full, 1);
        chk("bp_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(0, 5);
        drain();
        chk_log("bp_sum", '{1, 2, 3, 4, 5});

        // Steady stream: one in, one out per cycle.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send($urandom_range(0, 10), $urandom_range(0, 10));
        drain();
        chk("stream_txn_cnt", txn_cnt, 20);

        // Counter wrap after 256 pops.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) send(i % 16, (i * 7) % 16);
        drain();
        chk("wrap_255", txn_cnt, 255);
        send(3, 3);
        drain();
        chk("wrap_0", txn_cnt, 0);

        // Reset with entries in flight discards them.
        out_ready = 1'b0;
        send(1, 1); send(2, 2); send(3, 3);
        do_reset();
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_txn_cnt", txn_cnt, 0);
        @(posedge clk);
        #1;
        pop_log.delete();
        send(4, 3);
        drain();
        chk_log("post_rst_sum", '{7});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/add_responder.md
Name: add_responder

Overview:
- Responder end of the operand/sum transaction interface used by the adder test stimulus.
- Accepts operand pairs over a valid/ready input channel, computes the unsigned (W+1)-bit sum, and buffers results in a DEPTH-entry FIFO.
- Returns each result, with its echoed operands, over a valid/ready output channel.
- Maintains a wrapping count of completed transactions.

Parameters:
- W, 4, operand width in bits.
- DEPTH, 4, result FIFO entries; power of two, ≥2.
- CW, 8, width of the transaction counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  responder can accept an operand pair.
- in_a  input  W  operand a.
- in_b  input  W  operand b.
- out_valid  output  1  result at FIFO head is available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W+1  in_a + in_b, zero-extended, no truncation.
- out_a  output  W  echoed operand a of the head entry.
- out_b  output  W  echoed operand b of the head entry.
- txn_cnt  output  CW  number of results consumed; wraps modulo 2^CW.
- full  output  1  FIFO holds DEPTH entries.

Behaviour:
- Reset: when rst_n=0 at posedge, clear wr_ptr, rd_ptr, occupancy count, and txn_cnt to 0.
  - Outputs after reset: out_valid=0, full=0, in_ready=1, txn_cnt=0.
  - out_sum/out_a/out_b have don't-care contents while out_valid=0; the bench must not check them.
  - Reset overrides any handshake in the same cycle. In-flight entries are discarded and are not counted.
- Push: occurs when in_valid && in_ready at posedge.
  - Writes {in_a, in_b, in_a+in_b} into mem[wr_ptr]; wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready at posedge.
  - rd_ptr increments modulo DEPTH; txn_cnt increments, wrapping from 2^CW-1 to 0.
- Combinational outputs:
  - in_ready = (count != DEPTH).
  - out_valid = (count != 0).
  - full = (count == DEPTH).
  - out_sum/out_a/out_b are driven combinationally from mem[rd_ptr].
- Latency: a pair accepted at edge N, with the FIFO empty before N, gives out_valid=1 after edge N. It is poppable at edge N+1. There is no combinational pass-through from input to output.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged; both pointers advance.
- Full: in_ready=0. A simultaneous pop does not re-open in_ready in the same cycle; no push is accepted while full.
  - in_valid held high while full is legal. The operands must be held stable until accepted; the responder never drops or overwrites an entry.
- Empty: out_valid=0. out_ready is ignored, and txn_cnt does not change.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Arithmetic: the sum is computed at (W+1) width. Maximum value is 2^(W+1)-2 (30 for W=4).
- Ordering: strict FIFO; results leave in acceptance order.
- Protocol assertions for the bench:
  - out_valid never falls without a pop, except at reset.
  - out_* stay stable while out_valid && !out_ready.

Test Plan:
- Single transactions, out_ready=1:
  - Send (1,2), (0,9), (4,8), (7,9), one per cycle.
  - Required: sums 3, 9, 12, 16 in order. Each out_valid is high the cycle after its accept. txn_cnt=4 at the end.
- Maximum operands: send (15,15) then (15,0).
  - Required: out_sum=30 then 15. Bit 4 is set only for the first result.
- Back-pressure fill, out_ready=0:
  - Send (0,1), (0,2), (0,3), (0,4), (0,5) with in_valid held.
  - Required: 4 accepts; full=1 and in_ready=0 after the 4th accept; (0,5) remains pending.
  - Then raise out_ready: pops return sums 1, 2, 3, 4. (0,5) is accepted the cycle after the first pop, and sum 5 follows last.
- Simultaneous push/pop: steady stream of 20 random pairs from $urandom_range(0,10), with out_ready=1.
  - Required: count stays at 1 after the first accept. Every sum equals a+b. txn_cnt=20.
- Counter wrap: 256 transactions with CW=8.
  - Required: txn_cnt returns to 0 after the 256th pop.
- Reset mid-operation: with 3 entries queued, assert rst_n=0 for one cycle.
  - Required: the next cycle shows out_valid=0, in_ready=1, full=0, txn_cnt=0.
  - Then send (4,3): out_sum=7.
